depth_filter: RTL and testbench
===============================

# depth_filter

Downstream consumer of the IMU block's `raw_depth` word (ADC channel 0, 12 bits zero-extended to 32). It decimates the continuously refreshed ADC value to a fixed sample rate and applies a 2^LOG2_WINDOW boxcar average. It supports a one-shot surface calibration, then publishes absolute and zero-referenced depth with an update strobe for the Avalon register interface.

## Interface
- `SAMPLE_DIV`, default 50000, clk cycles per sample; legal values ≥ 2.
- `LOG2_WINDOW`, default 4, log2 of averaging window; legal range 1–6.
- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `raw_depth`  in  32  ADC word, already in `clk` domain; bits [11:0] used, [31:12] ignored.
- `zero_cal`  in  1  one-cycle pulse: latch current average as surface offset.
- `depth_avg`  out  32  averaged depth, zero-extended 12-bit.
- `depth_rel`  out  32  `depth_avg − offset`, 13-bit signed, sign-extended to 32.
- `depth_valid`  out  1  high once window has filled; level.
- `depth_update`  out  1  one-cycle pulse when outputs change.
- `sample_strobe`  out  1  one-cycle pulse on each sample capture (debug/LED).

## Operation
- Divider counter runs 0..SAMPLE_DIV−1 and wraps. `sample_strobe` is high in the cycle where count == SAMPLE_DIV−1. In that cycle `raw_depth[11:0]` is captured.
- Ring buffer of 2^LOG2_WINDOW × 12-bit entries with write pointer `wp` that wraps modulo window. On each sample, `sum <= sum + new − buf[wp]`, `buf[wp] <= new`, `wp <= wp+1`.
- Sum width is 12+LOG2_WINDOW bits. It can never overflow. The buffer is zero at reset, so the running-sum identity holds from the first sample.
- `depth_avg = sum >> LOG2_WINDOW`, truncating with no rounding.
- States:
  - FILL: fill counter counts samples. When the 2^LOG2_WINDOW-th sample is written, go to RUN.
  - RUN: remain until reset.
- `depth_valid` is 0 in FILL and 1 in RUN. `depth_avg` still updates during FILL as a partial sum, divided by the full window.
- `zero_cal` behaviour:
  - In RUN, the offset register takes the current registered `depth_avg`, not the in-flight sample.
  - In FILL, `zero_cal` is ignored.
  - If `zero_cal` and `sample_strobe` coincide, the offset takes the pre-update `depth_avg`.
- `depth_rel` is recomputed on every output update and in the cycle after an accepted `zero_cal`. `depth_update` pulses in both cases.
- Reset mid-operation clears counter, `wp`, fill count, sum, every buffer entry, offset and all outputs, and returns to FILL.

## Timing
- Cycle T has `sample_strobe` = 1. At the edge ending T, the buffer, sum and `wp` update.
- At the edge ending T+1, `depth_avg`, `depth_rel` and `depth_valid` register. `depth_update` = 1 during T+2.
- Latency from raw capture to output is 2 clk.
- Accepted `zero_cal` in cycle C updates the offset at the end of C. `depth_rel` updates at the end of C+1, with `depth_update` high in C+2.
- First `sample_strobe` occurs SAMPLE_DIV−1 cycles after reset deasserts, i.e. at count == SAMPLE_DIV−1.
- Reset values: all outputs 0; state FILL.

## Structure
- Shared package `imu_pkg` holds:
  - `ADC_WIDTH` = 12.
  - FILL/RUN state enum.
  - Helper constant for sum width.
- One sub-module `depth_ring_buffer`: buffer array, `wp`, and evicted-entry read-out, sized by LOG2_WINDOW.
- Divider, running sum, FSM and offset stay in `depth_filter`.

## Test plan
Run at SAMPLE_DIV=4, LOG2_WINDOW=3.
1. **Reset:** hold reset 5 cycles. Expect all outputs 0 and first `sample_strobe` 3 cycles after release.
2. **Constant input:** `raw_depth`=0x000_0800. After 8 samples, `depth_valid` rises with `depth_avg`=0x800. During fill, the partial averages are 0x100, 0x200, …, 0x800, each with `depth_update` 2 cycles after its strobe.
3. **Step and wrap:** after fill at 0x800, step to 0xFFF. Averages walk up to 0xFFF after 8 samples. Expect no overflow and correct eviction across the `wp` wrap.
4. **Calibration:** at avg 0x800, pulse `zero_cal`. Expect `depth_rel`=0. Then input 0x700 for 8 samples; expect `depth_rel`=0xFFFF_FF00 (−256).
5. **Simultaneous events:** `zero_cal` coincident with a strobe takes the pre-update average. `zero_cal` during FILL leaves the offset at 0.
6. **Reset mid-operation and ignored bits:** reset mid-RUN clears sum and buffer, and refill from 0x100 yields `depth_avg`=0x100 only after 8 samples. Bits [31:12] = 0xABCDE on `raw_depth` have no effect on any output.

Source files
------------

// File: rtl/imu_pkg.sv
// imu_pkg: shared ADC width, filter state encoding and sum-width helper
package imu_pkg;
  localparam int ADC_WIDTH = 12;
  typedef enum logic {FILL, RUN} fstate_e;
  function automatic int sum_width(int log2_window);
    return ADC_WIDTH + log2_window;
  endfunction
endpackage

// File: rtl/depth_filter_if.sv
// depth_filter_if: raw ADC input, calibration pulse and filtered depth outputs
interface depth_filter_if;
  logic [31:0] raw_depth;
  logic        zero_cal;
  logic [31:0] depth_avg;
  logic [31:0] depth_rel;
  logic        depth_valid;
  logic        depth_update;
  logic        sample_strobe;
  modport master (output raw_depth, zero_cal, input depth_avg, depth_rel, depth_valid, depth_update, sample_strobe);
  modport slave (input raw_depth, zero_cal, output depth_avg, depth_rel, depth_valid, depth_update, sample_strobe);
endinterface

// File: rtl/depth_ring_buffer.sv
// depth_ring_buffer: window of past samples with the entry about to be evicted exposed
module depth_ring_buffer import imu_pkg::*; #(
  parameter int LOG2_WINDOW = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we,
  input  logic [ADC_WIDTH-1:0] din,
  output logic [ADC_WIDTH-1:0] evict
);
  localparam int N = 1 << LOG2_WINDOW;
  logic [ADC_WIDTH-1:0] mem_q [N];
  logic [ADC_WIDTH-1:0] mem_d [N];
  logic [LOG2_WINDOW-1:0] wp_q, wp_d;
  assign evict = mem_q[wp_q];
  // write the new sample over the oldest entry and advance the pointer
  always_comb begin
    mem_d = mem_q;
    wp_d = we ? wp_q + LOG2_WINDOW'(1) : wp_q;
    if (we) mem_d[wp_q] = din;
  end
  // buffer clears to zero so the running sum is exact from the first sample
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q <= '{default: '0};
      wp_q <= '0;
    end else begin
      mem_q <= mem_d;
      wp_q <= wp_d;
    end
  end
endmodule

// File: rtl/depth_filter.sv
// depth_filter: decimated boxcar average of ADC depth with surface calibration
module depth_filter import imu_pkg::*; #(
  parameter int SAMPLE_DIV  = 50000,
  parameter int LOG2_WINDOW = 4
) (
  input logic           clk,
  input logic           reset,
  depth_filter_if.slave bus
);
  localparam int CW = $clog2(SAMPLE_DIV);
  localparam int SW = sum_width(LOG2_WINDOW);
  localparam int FW = LOG2_WINDOW + 1;
  localparam int W = 1 << LOG2_WINDOW;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] sum_q, sum_d;
  logic [FW-1:0] fill_q, fill_d;
  logic [ADC_WIDTH-1:0] sample, evict, offset_q, offset_d, avg_q, avg_d, avg_n;
  logic [ADC_WIDTH:0] rel_q, rel_d;
  fstate_e state_q, state_d;
  logic strobe, run, cal_ok;
  logic upd_q, upd_d, cal_q, cal_d, valid_q, valid_d, pulse_q, pulse_d;
  logic unused_raw;
  assign sample = bus.raw_depth[ADC_WIDTH-1:0];
  assign unused_raw = ^bus.raw_depth[31:ADC_WIDTH];
  assign strobe = cnt_q == CW'(SAMPLE_DIV - 1);
  depth_ring_buffer #(.LOG2_WINDOW(LOG2_WINDOW)) u_ring (
    .clk  (clk),
    .reset(reset),
    .we   (strobe),
    .din  (sample),
    .evict(evict)
  );
  // state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= FILL;
    else state_q <= state_d;
  end
  // leave FILL when the last sample of the first window is written
  always_comb begin
    state_d = (state_q == FILL && strobe && fill_q == FW'(W - 1)) ? RUN : state_q;
  end
  // calibration is only honoured once the window has filled
  always_comb begin
    run = state_q == RUN;
    cal_ok = bus.zero_cal && run;
  end
  // divider, running sum, two-stage output pipeline and offset
  always_comb begin
    cnt_d = strobe ? '0 : cnt_q + CW'(1);
    sum_d = strobe ? sum_q + SW'(sample) - SW'(evict) : sum_q;
    fill_d = (state_q == FILL && strobe) ? fill_q + FW'(1) : fill_q;
    upd_d = strobe;
    cal_d = cal_ok;
    offset_d = cal_ok ? avg_q : offset_q;
    avg_n = upd_q ? sum_q[SW-1:LOG2_WINDOW] : avg_q;
    avg_d = avg_n;
    rel_d = (upd_q || cal_q) ? {1'b0, avg_n} - {1'b0, offset_q} : rel_q;
    valid_d = upd_q ? run : valid_q;
    pulse_d = upd_q || cal_q;
  end
  // datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      sum_q <= '0;
      fill_q <= '0;
      upd_q <= 1'b0;
      cal_q <= 1'b0;
      offset_q <= '0;
      avg_q <= '0;
      rel_q <= '0;
      valid_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sum_q <= sum_d;
      fill_q <= fill_d;
      upd_q <= upd_d;
      cal_q <= cal_d;
      offset_q <= offset_d;
      avg_q <= avg_d;
      rel_q <= rel_d;
      valid_q <= valid_d;
      pulse_q <= pulse_d;
    end
  end
  assign bus.depth_avg = 32'(avg_q);
  assign bus.depth_rel = {{(32 - ADC_WIDTH - 1){rel_q[ADC_WIDTH]}}, rel_q};
  assign bus.depth_valid = valid_q;
  assign bus.depth_update = pulse_q;
  assign bus.sample_strobe = strobe;
endmodule

// File: tb/tb_depth_filter.sv
// tb_depth_filter: directed and random samples checked against a windowed-average model
module tb_depth_filter;
  localparam int SD = 4;
  localparam int LW = 3;
  localparam int W = 1 << LW;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;
  int hist[$];
  int nsamp = 0;
  int offs = 0;
  depth_filter_if bus();
  depth_filter #(.SAMPLE_DIV(SD), .LOG2_WINDOW(LW)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int mavg();
    int s = 0;
    foreach (hist[i]) s += hist[i];
    return s / W;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    bus.zero_cal = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_avg", bus.depth_avg, 0);
    chk("rst_rel", bus.depth_rel, 0);
    chk("rst_valid", 32'(bus.depth_valid), 0);
    chk("rst_update", 32'(bus.depth_update), 0);
    chk("rst_strobe", 32'(bus.sample_strobe), 0);
    hist.delete();
    nsamp = 0;
    offs = 0;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      chk("first_strobe", 32'(bus.sample_strobe), 32'(i == 3));
    end
  endtask

  task automatic do_sample(input logic [31:0] raw, input bit cal);
    int k = 0;
    int a;
    bus.raw_depth = raw;
    while (!bus.sample_strobe && k < 8) begin
      @(negedge clk);
      k++;
    end
    chk("strobe_seen", 32'(bus.sample_strobe), 1);
    bus.zero_cal = cal;
    if (cal && nsamp >= W) offs = mavg();
    hist.push_back(int'(raw[11:0]));
    if (hist.size() > W) void'(hist.pop_front());
    nsamp++;
    @(negedge clk);
    bus.zero_cal = 1'b0;
    chk("update_early", 32'(bus.depth_update), 0);
    @(negedge clk);
    a = mavg();
    chk("update", 32'(bus.depth_update), 1);
    chk("avg", bus.depth_avg, 32'(a));
    chk("rel", bus.depth_rel, 32'(a - offs));
    chk("valid", 32'(bus.depth_valid), 32'(nsamp >= W));
  endtask

  task automatic do_cal();
    bit acc;
    acc = nsamp >= W;
    bus.zero_cal = 1'b1;
    if (acc) offs = mavg();
    @(negedge clk);
    bus.zero_cal = 1'b0;
    chk("cal_update_early", 32'(bus.depth_update), 0);
    @(negedge clk);
    chk("cal_update", 32'(bus.depth_update), 32'(acc));
    chk("cal_rel", bus.depth_rel, 32'(mavg() - offs));
  endtask

  initial begin
    bus.raw_depth = '0;
    bus.zero_cal = 1'b0;
    do_reset();
    for (int i = 0; i < W; i++) do_sample(32'h800, 1'b0);
    chk("const_avg", bus.depth_avg, 32'h800);
    chk("const_valid", 32'(bus.depth_valid), 1);
    for (int i = 0; i < W; i++) do_sample(32'hFFF, 1'b0);
    chk("step_avg", bus.depth_avg, 32'hFFF);
    for (int i = 0; i < W; i++) do_sample(32'h800, 1'b0);
    do_cal();
    chk("cal_zero", bus.depth_rel, 32'h0);
    for (int i = 0; i < W; i++) do_sample(32'h700, 1'b0);
    chk("rel_neg", bus.depth_rel, 32'hFFFF_FF00);
    do_sample(32'hF00, 1'b1);
    chk("cal_coincident", bus.depth_rel, 32'h100);
    for (int i = 0; i < 24; i++) begin
      int mode;
      logic [31:0] r;
      r = $urandom;
      mode = $urandom_range(0, 3);
      if (mode == 0) do_cal();
      do_sample(r, mode == 1);
    end
    do_reset();
    do_sample(32'hABCD_E100, 1'b0);
    do_cal();
    for (int i = 0; i < W - 2; i++) do_sample(32'hABCD_E100, 1'b0);
    chk("refill_not_valid", 32'(bus.depth_valid), 0);
    do_sample(32'hABCD_E100, 1'b0);
    chk("refill_valid", 32'(bus.depth_valid), 1);
    chk("refill_avg", bus.depth_avg, 32'h100);
    chk("refill_rel", bus.depth_rel, 32'h100);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
